counter_scheduler: RTL and testbench

- Time-shares one down-counting interval timer among N requesters.
- Each requester asks for an interval of dur+1 timer ticks. The scheduler grants requesters round-robin, loads and runs the shared count, then pulses a per-requester done.
- Sits beside the counter datapath and is the sole driver of its load/enable sequencing. Used for stall/delay timing in pipeline control.

---
 rtl/util_pkg.sv | 16 +
 rtl/counter_scheduler_if.sv | 36 +++
 rtl/counter_scheduler.sv | 142 ++++++++++++++
 tb/tb_counter_scheduler.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/util_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : util_pkg
//  Description : Shared utility types. Util_Control_T bundles the clock and
//                the synchronous active-high reset that drive a block.
//  Revision    : 1.0 - initial release
// ============================================================================
package util_pkg;

    typedef struct packed {
        logic clk;   // rising-edge clock
        logic rst;   // synchronous, active-high reset
    } Util_Control_T;

endpackage
`default_nettype wire

// File: rtl/counter_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Interface   : counter_scheduler_if
//  Description : Request/grant/completion bundle between N requesters and the
//                shared interval-timer scheduler. The master side raises
//                requests with their durations, and the slave side (the
//                scheduler) returns grant, count and done.
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_scheduler_if #(
    parameter int N = 4,
    parameter int W = 4
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;    // per-requester request level
    logic [N*W-1:0] dur;    // requester i duration at [i*W +: W]
    logic           hold;   // pause the running count
    logic [N-1:0]   gnt;    // one-hot grant, 0 when idle
    logic [PW-1:0]  owner;  // current or last owner index
    logic           busy;   // high in LOAD and RUN
    logic [W-1:0]   q;      // current count
    logic [N-1:0]   done;   // one-cycle one-hot completion pulse

    modport master (
        output req, dur, hold,
        input  gnt, owner, busy, q, done
    );

    modport slave (
        input  req, dur, hold,
        output gnt, owner, busy, q, done
    );

endinterface
`default_nettype wire

// File: rtl/counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : counter_scheduler
//  Description : Time-shares one down-counting interval timer among N
//                requesters. Grants round-robin, loads the owner's duration,
//                counts it down (dur+1 RUN cycles, pausable by hold), then
//                pulses a one-hot done. Dropping the request mid-count
//                abandons the grant without a done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_scheduler #(
    parameter int N = 4,
    parameter int W = 4
) (
    input  util_pkg::Util_Control_T ctrl,
    counter_scheduler_if.slave      bus
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

    logic clk;
    logic rst;
    assign clk = ctrl.clk;
    assign rst = ctrl.rst;

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_owner;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_done;
    logic          r_busy;
    logic [W-1:0]  r_q;

    logic          w_found;
    logic [PW-1:0] w_win;
    logic [PW:0]   w_idx;
    logic [PW-1:0] w_owner_next;
    logic [W-1:0]  w_dur_sel;

    // Round-robin search: first set request at or above ptr, wrapping at N.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N)) begin
                w_idx = w_idx - (PW+1)'(N);
            end
            if (!w_found && bus.req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    // Pointer value that places the current owner last in the next search.
    always_comb begin
        if (r_owner == PW'(N - 1)) begin
            w_owner_next = '0;
        end else begin
            w_owner_next = r_owner + 1'b1;
        end
    end

    // Duration field of the current owner, used only on the LOAD edge.
    always_comb begin
        w_dur_sel = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == PW'(i)) begin
                w_dur_sel = bus.dur[i*W +: W];
            end
        end
    end

    // Scheduler state machine; every output is a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_q     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_gnt   <= c_one << w_win;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_q     <= w_dur_sel;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (!bus.req[r_owner]) begin
                        // Abandoned: release without a done pulse, count frozen.
                        r_state <= S_IDLE;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                        r_ptr   <= w_owner_next;
                    end else if (bus.hold) begin
                        r_q <= r_q;
                    end else if (r_q == '0) begin
                        r_state <= S_DONE;
                        r_done  <= c_one << r_owner;
                        r_gnt   <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_q <= r_q - 1'b1;
                    end
                end
                default: begin
                    // S_DONE: done was high for this one cycle.
                    r_done  <= '0;
                    r_ptr   <= w_owner_next;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.gnt   = r_gnt;
    assign bus.owner = r_owner;
    assign bus.busy  = r_busy;
    assign bus.q     = r_q;
    assign bus.done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_scheduler
//  Description : Self-checking bench for counter_scheduler. Expected done
//                pulses (mask and cycle) are queued when stimulus is applied
//                and a monitor pops and compares them as done pulses appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_scheduler;

    localparam int N = 4;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    util_pkg::Util_Control_T ctrl;
    assign ctrl.clk = clk;
    assign ctrl.rst = rst;

    counter_scheduler_if #(.N(N), .W(W)) bus ();

    counter_scheduler #(.N(N), .W(W)) dut (
        .ctrl (ctrl),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [N-1:0] mask;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;
    bit   mon_en    = 1'b0;

    // Done monitor: every pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (mon_en && bus.done !== '0) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL done_unexpected got=%b required=none cyc=%0d", bus.done, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.done !== e.mask || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL done got=%b@%0d required=%b@%0d", bus.done, cyc, e.mask, e.cyc);
                end
            end
        end
    end

    task automatic pulse_reset();
        @(negedge clk);
        rst      = 1'b1;
        bus.req  = '0;
        bus.hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.req  = '1;
        bus.hold = 1'b0;
        bus.dur  = '1;
        rst      = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests_run++;
            if ({bus.gnt, bus.done, bus.busy, bus.q, bus.owner} !== '0) begin
                fails++;
                $display("FAIL reset gnt=%b done=%b busy=%b q=%h owner=%0d required all 0",
                         bus.gnt, bus.done, bus.busy, bus.q, bus.owner);
            end
        end
        rst     = 1'b0;
        bus.req = '0;
        bus.dur = '0;
        mon_en  = 1'b1;
    endtask

    task automatic test_single();
        int c0;
        logic [N-1:0] eg;
        logic [W-1:0] eq;
        pulse_reset();
        bus.dur[2*W +: W] = 4'd3;
        bus.req = 4'b0100;
        c0 = cyc;
        sb.push_back('{4'b0100, c0 + 6});
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            eg = (k <= 5) ? 4'b0100 : 4'b0000;
            eq = (k == 1 || k >= 5) ? 4'd0 : W'(5 - k);
            tests_run++;
            if (bus.gnt !== eg || bus.busy !== (k <= 5) || bus.q !== eq) begin
                fails++;
                $display("FAIL single k=%0d gnt=%b busy=%b q=%0d required gnt=%b busy=%b q=%0d",
                         k, bus.gnt, bus.busy, bus.q, eg, (k <= 5), eq);
            end
            if (k == 1) begin
                tests_run++;
                if (bus.owner !== 2'd2) begin
                    fails++;
                    $display("FAIL single_owner got=%0d required=2", bus.owner);
                end
            end
            if (k == 6) bus.req = '0;
        end
    endtask

    task automatic test_round_robin();
        int gexp[$];
        int c0;
        logic [N-1:0] prev;
        pulse_reset();
        bus.dur = '0;
        for (int ph = 0; ph < 2; ph++) begin
            c0 = cyc;
            prev = '0;
            if (ph == 0) begin
                bus.req = 4'b1011;
                gexp = '{0, 1, 3};
                sb.push_back('{4'b0001, c0 + 3});
                sb.push_back('{4'b0010, c0 + 7});
                sb.push_back('{4'b1000, c0 + 11});
            end else begin
                bus.req = 4'b0011;
                gexp = '{0, 1};
                sb.push_back('{4'b0001, c0 + 3});
                sb.push_back('{4'b0010, c0 + 7});
            end
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.gnt !== '0 && prev === '0) begin
                    tests_run++;
                    if (gexp.size() == 0) begin
                        fails++;
                        $display("FAIL rr_extra_grant got=%0d required=none", bus.owner);
                    end else if (int'(bus.owner) != gexp[0]) begin
                        fails++;
                        $display("FAIL rr_order ph=%0d got=%0d required=%0d", ph, bus.owner, gexp[0]);
                        void'(gexp.pop_front());
                    end else begin
                        void'(gexp.pop_front());
                    end
                end
                prev = bus.gnt;
                if (bus.done !== '0) bus.req = bus.req & ~bus.done;
                if (bus.req == '0 && !bus.busy && bus.done === '0) break;
            end
            tests_run++;
            if (gexp.size() != 0) begin
                fails++;
                $display("FAIL rr_missing ph=%0d got=%0d grants_left required=0", ph, gexp.size());
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        int c0;
        pulse_reset();
        bus.dur = '0;
        bus.dur[0 +: W] = 4'd2;
        bus.req = 4'b0001;
        c0 = cyc;
        sb.push_back('{4'b0001, c0 + 8});
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k >= 3 && k <= 6) begin
                tests_run++;
                if (bus.q !== 4'd1 || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL hold k=%0d q=%0d busy=%b required q=1 busy=1", k, bus.q, bus.busy);
                end
            end
            if (k == 7) begin
                tests_run++;
                if (bus.q !== 4'd0) begin
                    fails++;
                    $display("FAIL hold_release q=%0d required=0", bus.q);
                end
            end
            if (k == 3) bus.hold = 1'b1;
            if (k == 6) bus.hold = 1'b0;
            if (bus.done !== '0) bus.req = bus.req & ~bus.done;
        end
    endtask

    task automatic test_abandon();
        int c0;
        pulse_reset();
        bus.dur = '0;
        bus.dur[1*W +: W] = 4'd9;
        bus.dur[2*W +: W] = 4'd1;
        bus.req = 4'b0010;
        c0 = cyc;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 3) bus.req = bus.req | 4'b0101;
            if (k == 6) begin
                tests_run++;
                if (bus.q !== 4'd5) begin
                    fails++;
                    $display("FAIL abandon_pre q=%0d required=5", bus.q);
                end
                bus.req[1] = 1'b0;
                sb.push_back('{4'b0100, c0 + 11});
                sb.push_back('{4'b0001, c0 + 15});
            end
            if (k == 7) begin
                tests_run++;
                if (bus.gnt !== '0 || bus.busy !== 1'b0 || bus.done !== '0 || bus.q !== 4'd5) begin
                    fails++;
                    $display("FAIL abandon gnt=%b busy=%b done=%b q=%0d required gnt=0 busy=0 done=0 q=5",
                             bus.gnt, bus.busy, bus.done, bus.q);
                end
            end
            if (k == 8) begin
                tests_run++;
                if (bus.gnt !== 4'b0100 || bus.owner !== 2'd2) begin
                    fails++;
                    $display("FAIL abandon_next gnt=%b owner=%0d required gnt=0100 owner=2", bus.gnt, bus.owner);
                end
            end
            if (k == 13) begin
                tests_run++;
                if (bus.gnt !== 4'b0001) begin
                    fails++;
                    $display("FAIL abandon_then0 gnt=%b required=0001", bus.gnt);
                end
            end
            if (bus.done !== '0) bus.req = bus.req & ~bus.done;
        end
    endtask

    task automatic test_boundary();
        int c0;
        int busy_cnt;
        pulse_reset();
        bus.dur = '0;
        bus.dur[3*W +: W] = 4'hF;
        bus.req = 4'b1000;
        c0 = cyc;
        busy_cnt = 0;
        sb.push_back('{4'b1000, c0 + 18});
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (bus.busy === 1'b1) busy_cnt++;
            if (k >= 2) begin
                tests_run++;
                if (bus.q !== ((k <= 17) ? W'(17 - k) : 4'd0)) begin
                    fails++;
                    $display("FAIL boundary_q k=%0d got=%0d required=%0d", k, bus.q, (k <= 17) ? 17 - k : 0);
                end
            end
            if (bus.done !== '0) bus.req = bus.req & ~bus.done;
        end
        tests_run++;
        if (busy_cnt != 17) begin
            fails++;
            $display("FAIL boundary_busy_cycles got=%0d required=17", busy_cnt);
        end
        // Start again and reset in the middle of the count.
        @(negedge clk);
        bus.req = 4'b1000;
        for (int k = 1; k <= 4; k++) @(negedge clk);
        tests_run++;
        if (bus.q !== 4'd13) begin
            fails++;
            $display("FAIL midreset_pre q=%0d required=13", bus.q);
        end
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({bus.gnt, bus.done, bus.busy, bus.q, bus.owner} !== '0) begin
            fails++;
            $display("FAIL midreset gnt=%b done=%b busy=%b q=%0d owner=%0d required all 0",
                     bus.gnt, bus.done, bus.busy, bus.q, bus.owner);
        end
        // After reset ptr is 0, so requester 0 beats requester 1.
        bus.dur = '0;
        bus.req = 4'b0011;
        c0 = cyc;
        sb.push_back('{4'b0001, c0 + 3});
        sb.push_back('{4'b0010, c0 + 7});
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus.done !== '0) bus.req = bus.req & ~bus.done;
        end
    endtask

    initial begin
        bus.req  = '0;
        bus.dur  = '0;
        bus.hold = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_abandon();
        test_boundary();
        repeat (3) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL done_missing got=%0d pending required=0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
`default_nettype wire
